spio_spinnaker_link_pkt_serializer: RTL and testbench
=====================================================

SPIO_SPINNAKER_LINK_PKT_SERIALIZER -- requirements
Module: spio_spinnaker_link_pkt_serializer

Interface
REQ-001 SHALL have no parameters.
REQ-002 CLK_IN  input  1  single clock; all state changes on its rising edge.
REQ-003 RESET_IN  input  1  reset; synchronous, active-low (0 = reset, sampled on CLK_IN).
REQ-004 PKT_DATA_IN  input  72  packet; [7:0] header, [39:8] key, [71:40] payload. Bit 1 of the header set means payload present.
REQ-005 PKT_VLD_IN  input  1  packet valid.
REQ-006 PKT_RDY_OUT  output  1  packet ready; a packet transfers when PKT_VLD_IN and PKT_RDY_OUT are both 1 on a clock edge.
REQ-007 flt_data_2of7  output  7  NRZ 2-of-7 flit to the sync-to-async FIFO.
REQ-008 flt_vld  output  1  flit valid.
REQ-009 flt_rdy  input  1  flit ready from the FIFO; a flit transfers when flt_vld and flt_rdy are both 1 on a clock edge.

Function
REQ-010 SHALL implement FSM states IDLE, SEND and EOP. All outputs SHALL be registered.
REQ-011 IDLE: PKT_RDY_OUT=1 and flt_vld=0. On packet transfer, the block SHALL latch PKT_DATA_IN, set the nibble counter to 0, and go to SEND. PKT_RDY_OUT SHALL be 0 in every other state.
REQ-012 Packet length: header[1]=0 gives 10 nibbles (bits [39:0]). header[1]=1 gives 18 nibbles (bits [71:0]).
REQ-013 Nibble order: least-significant first; nibble n = latched bits [4n+3:4n].
REQ-014 2-of-7 symbol code table:
- 0=0x11, 1=0x12, 2=0x14, 3=0x18
- 4=0x21, 5=0x22, 6=0x24, 7=0x28
- 8=0x41, 9=0x42, A=0x44, B=0x48
- C=0x03, D=0x06, E=0x0C, F=0x09
- EOP=0x60
REQ-015 NRZ encoding: the block SHALL hold register last_flit (7 bits). The presented flit SHALL equal last_flit XOR code. On each flit transfer, last_flit SHALL be loaded with the transferred flit.
REQ-016 SEND: flt_vld=1 with the current nibble's flit. On transfer, the counter SHALL increment. After the last nibble transfers, the FSM SHALL go to EOP.
REQ-017 EOP: flt_vld=1 with flit last_flit XOR 0x60. On transfer, the FSM SHALL go to IDLE.
REQ-018 When the FIFO has room (flt_rdy held high), flits SHALL transfer every cycle. The next flit SHALL be presented in the cycle following a transfer.
REQ-019 The block SHALL not accept a packet while flits are outstanding. There SHALL be exactly one IDLE cycle between an EOP transfer and the next packet acceptance. The first flit of the accepted packet SHALL be valid in the cycle after acceptance.
REQ-020 Backpressure: while flt_vld=1 and flt_rdy=0, flt_data_2of7 and flt_vld SHALL hold stable, and the counter and last_flit SHALL not change.
REQ-021 flt_vld SHALL never deassert before its flit transfers.
REQ-022 The nibble counter SHALL be 5 bits. It SHALL not wrap within a packet, and it SHALL be cleared on every acceptance.
REQ-023 Header contents other than bit 1, including parity, SHALL pass through unmodified. No parity is generated or checked.

Reset
REQ-024 With RESET_IN=0 at a clock edge, the block SHALL set:
- FSM to IDLE
- PKT_RDY_OUT=0 during reset, then 1 from the first edge after release
- flt_vld=0
- flt_data_2of7=0
- last_flit=0
- counter=0
REQ-025 Reset mid-packet SHALL abandon the packet. No EOP is sent. The first flit after reset SHALL be NRZ-relative to 0, matching the FIFO's reset output of 0.
REQ-026 Latched packet contents need no reset.

Verification
REQ-027 Short packet, header 0x00, key 0x12345678, flt_rdy=1 -> 11 flits on consecutive cycles, starting 0x11, 0x00, 0x41, 0x69. The last flit equals the 10th flit XOR 0x60. PKT_RDY_OUT then returns to 1.
REQ-028 Long packet, header 0x02, payload 0xFFFFFFFF -> exactly 19 flits. Flits 11-18 each toggle 0x09 relative to the previous flit. Flit 19 is the EOP.
REQ-029 flt_rdy toggled pseudo-randomly during a long packet -> flit sequence identical to the no-backpressure case. Data and flt_vld are stable during every stall.
REQ-030 Two packets offered back-to-back -> the second is accepted exactly 2 cycles after the first packet's EOP transfer. NRZ continues from the first packet's final last_flit.
REQ-031 RESET_IN=0 for 1 cycle after the 5th flit of a packet -> flt_vld=0 and data 0 next cycle. A new short packet then produces 0x11 as its first flit.
REQ-032 PKT_VLD_IN=1 while in SEND/EOP -> no acceptance and no change to the latched packet.

Source files
------------

// File: rtl/spio_spinnaker_link_pkt_serializer.sv
// rtl/spio_spinnaker_link_pkt_serializer.sv - SpiNNaker link packet to NRZ 2-of-7 flit serializer
module spio_spinnaker_link_pkt_serializer (
    input  logic        CLK_IN,
    input  logic        RESET_IN,
    input  logic [71:0] PKT_DATA_IN,
    input  logic        PKT_VLD_IN,
    output logic        PKT_RDY_OUT,
    output logic [6:0]  flt_data_2of7,
    output logic        flt_vld,
    input  logic        flt_rdy
);

    localparam logic [6:0] EOP_SYM = 7'h60;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        EOP  = 2'd2
    } state_t;

    state_t      state_q;
    logic [71:0] pkt_q;
    logic [4:0]  cnt_q;
    logic [6:0]  last_flit_q;
    logic [6:0]  flt_data_q;
    logic        flt_vld_q;
    logic        pkt_rdy_q;

    logic [4:0]  cnt_d;
    logic [3:0]  next_nib;
    logic        last_nib;
    logic        pkt_xfer;
    logic        flt_xfer;

    function automatic logic [6:0] sym_2of7(input logic [3:0] nib);
        logic [6:0] sym;
        case (nib)
            4'h0:    sym = 7'h11;
            4'h1:    sym = 7'h12;
            4'h2:    sym = 7'h14;
            4'h3:    sym = 7'h18;
            4'h4:    sym = 7'h21;
            4'h5:    sym = 7'h22;
            4'h6:    sym = 7'h24;
            4'h7:    sym = 7'h28;
            4'h8:    sym = 7'h41;
            4'h9:    sym = 7'h42;
            4'hA:    sym = 7'h44;
            4'hB:    sym = 7'h48;
            4'hC:    sym = 7'h03;
            4'hD:    sym = 7'h06;
            4'hE:    sym = 7'h0C;
            default: sym = 7'h09;
        endcase
        return sym;
    endfunction

    assign pkt_xfer = PKT_VLD_IN && pkt_rdy_q;
    assign flt_xfer = flt_vld_q && flt_rdy;
    assign cnt_d    = cnt_q + 5'd1;
    // header bit 1 selects the long (payload-carrying) packet format
    assign last_nib = (cnt_q == (pkt_q[1] ? 5'd17 : 5'd9));

    always_comb begin
        next_nib = 4'h0;
        for (int i = 0; i < 18; i++) begin
            if (cnt_d == 5'(i)) begin
                next_nib = pkt_q[4*i +: 4];
            end
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (pkt_xfer) begin
            pkt_q <= PKT_DATA_IN;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (!RESET_IN) begin
            state_q     <= IDLE;
            pkt_rdy_q   <= 1'b0;
            flt_vld_q   <= 1'b0;
            flt_data_q  <= 7'h00;
            last_flit_q <= 7'h00;
            cnt_q       <= 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pkt_xfer) begin
                        pkt_rdy_q  <= 1'b0;
                        cnt_q      <= 5'd0;
                        flt_vld_q  <= 1'b1;
                        flt_data_q <= last_flit_q ^ sym_2of7(PKT_DATA_IN[3:0]);
                        state_q    <= SEND;
                    end else begin
                        pkt_rdy_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (flt_xfer) begin
                        last_flit_q <= flt_data_q;
                        cnt_q       <= cnt_d;
                        if (last_nib) begin
                            flt_data_q <= flt_data_q ^ EOP_SYM;
                            state_q    <= EOP;
                        end else begin
                            flt_data_q <= flt_data_q ^ sym_2of7(next_nib);
                        end
                    end
                end
                EOP: begin
                    // ready is raised one cycle after re-entering IDLE
                    if (flt_xfer) begin
                        last_flit_q <= flt_data_q;
                        flt_vld_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    pkt_rdy_q <= 1'b0;
                    flt_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign PKT_RDY_OUT   = pkt_rdy_q;
    assign flt_vld       = flt_vld_q;
    assign flt_data_2of7 = flt_data_q;

endmodule

// File: tb/tb_spio_spinnaker_link_pkt_serializer.sv
// tb/tb_spio_spinnaker_link_pkt_serializer.sv - self-checking bench for the packet serializer
module tb_spio_spinnaker_link_pkt_serializer;

    logic        CLK_IN = 1'b0;
    logic        RESET_IN;
    logic [71:0] PKT_DATA_IN;
    logic        PKT_VLD_IN;
    logic        PKT_RDY_OUT;
    logic [6:0]  flt_data_2of7;
    logic        flt_vld;
    logic        flt_rdy;

    int errors = 0;
    int checks = 0;
    logic [6:0] model_last;
    logic [6:0] obs[$];

    spio_spinnaker_link_pkt_serializer dut (
        .CLK_IN        (CLK_IN),
        .RESET_IN      (RESET_IN),
        .PKT_DATA_IN   (PKT_DATA_IN),
        .PKT_VLD_IN    (PKT_VLD_IN),
        .PKT_RDY_OUT   (PKT_RDY_OUT),
        .flt_data_2of7 (flt_data_2of7),
        .flt_vld       (flt_vld),
        .flt_rdy       (flt_rdy)
    );

    always #5 CLK_IN = ~CLK_IN;

    function automatic logic [6:0] sym(input logic [3:0] v);
        case (v)
            4'h0: return 7'h11;  4'h1: return 7'h12;  4'h2: return 7'h14;  4'h3: return 7'h18;
            4'h4: return 7'h21;  4'h5: return 7'h22;  4'h6: return 7'h24;  4'h7: return 7'h28;
            4'h8: return 7'h41;  4'h9: return 7'h42;  4'hA: return 7'h44;  4'hB: return 7'h48;
            4'hC: return 7'h03;  4'hD: return 7'h06;  4'hE: return 7'h0C;  default: return 7'h09;
        endcase
    endfunction

    function automatic logic [71:0] rand_pkt();
        return {8'($urandom), $urandom, $urandom};
    endfunction

    // Called at a negedge; offers pkt and follows it through to its EOP transfer.
    task automatic run_packet(input logic [71:0] pkt, input int stall_pct, input bit hold_vld,
                              input int exp_acc, input string name);
        logic [6:0] exp_q[$];
        logic [6:0] l, fd, prev_d;
        logic pv, fv;
        int n, got, iter, acc_iter;
        bit acc, just_acc, stalled;
        l = model_last;
        n = pkt[1] ? 18 : 10;
        for (int i = 0; i < n; i++) begin
            l = l ^ sym(pkt[4*i +: 4]);
            exp_q.push_back(l);
        end
        exp_q.push_back(l ^ 7'h60);
        model_last = exp_q[n];
        obs.delete();
        got = 0; iter = 0; acc_iter = 0; acc = 0; just_acc = 0; stalled = 0; prev_d = '0;
        PKT_DATA_IN = pkt;
        PKT_VLD_IN  = 1'b1;
        while (got < exp_q.size() && iter < 400) begin
            pv = PKT_RDY_OUT; fv = flt_vld; fd = flt_data_2of7;
            if (stalled) begin
                checks++;
                if (fv !== 1'b1 || fd !== prev_d) begin
                    errors++;
                    $display("FAIL %s stall_hold: vld=%b data=%h required vld=1 data=%h", name, fv, fd, prev_d);
                end
            end
            if (just_acc) begin
                checks++;
                if (fv !== 1'b1 || fd !== exp_q[0]) begin
                    errors++;
                    $display("FAIL %s first_flit: vld=%b data=%h required vld=1 data=%h", name, fv, fd, exp_q[0]);
                end
            end
            if (acc) begin
                checks++;
                if (fv !== 1'b1 || pv !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy: vld=%b rdy=%b required vld=1 rdy=0", name, fv, pv);
                end
            end else begin
                checks++;
                if (fv !== 1'b0) begin
                    errors++;
                    $display("FAIL %s idle_vld: vld=%b required 0", name, fv);
                end
            end
            flt_rdy = ($urandom_range(99) >= stall_pct);
            @(posedge CLK_IN);
            iter++;
            just_acc = 0;
            if (!acc && pv === 1'b1) begin
                acc = 1; just_acc = 1; acc_iter = iter;
            end
            if (fv === 1'b1 && flt_rdy) begin
                checks++;
                if (fd !== exp_q[got]) begin
                    errors++;
                    $display("FAIL %s flit%0d: got %h required %h", name, got, fd, exp_q[got]);
                end
                obs.push_back(fd);
                got++;
            end
            stalled = (fv === 1'b1) && !flt_rdy;
            prev_d  = fd;
            @(negedge CLK_IN);
            if (acc) begin
                PKT_VLD_IN  = hold_vld;
                PKT_DATA_IN = rand_pkt();
            end
        end
        checks++;
        if (got != exp_q.size()) begin
            errors++;
            $display("FAIL %s timeout: flits=%0d required %0d", name, got, exp_q.size());
        end
        if (exp_acc > 0) begin
            checks++;
            if (acc_iter != exp_acc) begin
                errors++;
                $display("FAIL %s accept_cycle: got %0d required %0d", name, acc_iter, exp_acc);
            end
        end
        if (stall_pct == 0) begin
            checks++;
            if (iter - acc_iter != exp_q.size()) begin
                errors++;
                $display("FAIL %s consecutive: cycles=%0d required %0d", name, iter - acc_iter, exp_q.size());
            end
        end
        checks++;
        if (flt_vld !== 1'b0 || PKT_RDY_OUT !== 1'b0) begin
            errors++;
            $display("FAIL %s post_eop: vld=%b rdy=%b required vld=0 rdy=0", name, flt_vld, PKT_RDY_OUT);
        end
    endtask

    task automatic test_reset();
        RESET_IN = 1'b0; PKT_VLD_IN = 1'b0; flt_rdy = 1'b0; PKT_DATA_IN = '0;
        repeat (3) @(negedge CLK_IN);
        checks++;
        if (PKT_RDY_OUT !== 1'b0 || flt_vld !== 1'b0 || flt_data_2of7 !== 7'h00) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b data=%h required 0 0 00", PKT_RDY_OUT, flt_vld, flt_data_2of7);
        end
        RESET_IN = 1'b1;
        @(negedge CLK_IN);
        checks++;
        if (PKT_RDY_OUT !== 1'b1 || flt_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b vld=%b required rdy=1 vld=0", PKT_RDY_OUT, flt_vld);
        end
        model_last = 7'h00;
    endtask

    task automatic test_short();
        logic [6:0] ref4 [4];
        ref4 = '{7'h11, 7'h00, 7'h41, 7'h69};
        run_packet({32'h0, 32'h12345678, 8'h00}, 0, 1'b0, 1, "short");
        checks++;
        if (obs.size() != 11) begin
            errors++;
            $display("FAIL short_len: got %0d required 11", obs.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs[i] !== ref4[i]) begin
                    errors++;
                    $display("FAIL short_flit%0d: got %h required %h", i, obs[i], ref4[i]);
                end
            end
            checks++;
            if (obs[10] !== (obs[9] ^ 7'h60)) begin
                errors++;
                $display("FAIL short_eop: got %h required %h", obs[10], obs[9] ^ 7'h60);
            end
        end
        @(negedge CLK_IN);
        checks++;
        if (PKT_RDY_OUT !== 1'b1) begin
            errors++;
            $display("FAIL short_rdy_return: got %b required 1", PKT_RDY_OUT);
        end
    endtask

    task automatic test_long();
        run_packet({32'hFFFFFFFF, $urandom, 8'h02}, 0, 1'b0, 1, "long");
        checks++;
        if (obs.size() != 19) begin
            errors++;
            $display("FAIL long_len: got %0d required 19", obs.size());
        end else begin
            for (int i = 10; i < 18; i++) begin
                checks++;
                if ((obs[i] ^ obs[i-1]) !== 7'h09) begin
                    errors++;
                    $display("FAIL long_toggle%0d: got %h required 09", i, obs[i] ^ obs[i-1]);
                end
            end
            checks++;
            if (obs[18] !== (obs[17] ^ 7'h60)) begin
                errors++;
                $display("FAIL long_eop: got %h required %h", obs[18], obs[17] ^ 7'h60);
            end
        end
        @(negedge CLK_IN);
    endtask

    task automatic test_backpressure();
        run_packet(rand_pkt() | 72'h2, 50, 1'b0, 1, "bp_long");
        @(negedge CLK_IN);
        run_packet(rand_pkt() & ~72'h2, 40, 1'b0, 1, "bp_short");
        @(negedge CLK_IN);
    endtask

    task automatic test_back_to_back();
        run_packet(rand_pkt() & ~72'h2, 0, 1'b1, 1, "b2b_first");
        run_packet(rand_pkt() | 72'h2, 0, 1'b1, 2, "b2b_second");
        for (int k = 0; k < 6; k++) begin
            run_packet(rand_pkt(), $urandom_range(60), $urandom_range(1), 2, "random");
        end
        PKT_VLD_IN = 1'b0;
        @(negedge CLK_IN);
    endtask

    task automatic test_mid_reset();
        int n, cyc;
        bit acc;
        logic pv, fv;
        PKT_DATA_IN = rand_pkt() | 72'h2; PKT_VLD_IN = 1'b1; flt_rdy = 1'b1;
        n = 0; cyc = 0; acc = 0;
        while (n < 5 && cyc < 100) begin
            pv = PKT_RDY_OUT; fv = flt_vld;
            @(posedge CLK_IN);
            cyc++;
            if (pv === 1'b1) acc = 1;
            if (fv === 1'b1) n++;
            @(negedge CLK_IN);
            if (acc) PKT_VLD_IN = 1'b0;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL midrst_flits: got %0d required 5", n);
        end
        RESET_IN = 1'b0;
        @(negedge CLK_IN);
        checks++;
        if (flt_vld !== 1'b0 || flt_data_2of7 !== 7'h00 || PKT_RDY_OUT !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: vld=%b data=%h rdy=%b required 0 00 0", flt_vld, flt_data_2of7, PKT_RDY_OUT);
        end
        RESET_IN = 1'b1;
        model_last = 7'h00;
        @(negedge CLK_IN);
        run_packet({32'h0, $urandom, 8'h00}, 0, 1'b0, 1, "midrst_next");
        checks++;
        if (obs.size() == 0 || obs[0] !== 7'h11) begin
            errors++;
            $display("FAIL midrst_first: got %h required 11", (obs.size() == 0) ? 7'h7F : obs[0]);
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        PKT_VLD_IN = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
